// File: rtl/l2_pkg.sv
// -----------------------------------------------------------------------------
// l2_pkg
// Shared widths and types for the L2-norm square-root stage.
//   IN_W         radicand (sum-of-squares) width, must be even
//   OUT_W        root width, IN_W/2
//   sqrt_state_t FSM state encoding of the bit-serial square root
//   fifo_entry_t one buffered input sample: overflow tag plus radicand
// -----------------------------------------------------------------------------
package l2_pkg;

    localparam int IN_W  = 10;
    localparam int OUT_W = IN_W / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sqrt_state_t;

    typedef struct packed {
        logic            ovf;
        logic [IN_W-1:0] g;
    } fifo_entry_t;

endpackage

// File: rtl/l2_sqrt_stage_if.sv
// -----------------------------------------------------------------------------
// l2_sqrt_stage_if
// Sample/result bundle between the sum-of-squares producer, the square-root
// stage and its consumer.
//   g_in, valid_in, ovf_in   input sample stream (no backpressure)
//   root, rem, ovf_out       result and its overflow tag
//   valid_out                one-cycle result strobe
//   fifo_full, drop          input buffer status; drop is sticky
// master: the environment driving samples; slave: the square-root stage.
// -----------------------------------------------------------------------------
interface l2_sqrt_stage_if;
    import l2_pkg::*;

    logic [IN_W-1:0]  g_in;
    logic             valid_in;
    logic             ovf_in;
    logic [OUT_W-1:0] root;
    logic [OUT_W:0]   rem;
    logic             valid_out;
    logic             ovf_out;
    logic             fifo_full;
    logic             drop;

    modport master (
        output g_in, valid_in, ovf_in,
        input  root, rem, valid_out, ovf_out, fifo_full, drop
    );

    modport slave (
        input  g_in, valid_in, ovf_in,
        output root, rem, valid_out, ovf_out, fifo_full, drop
    );

endinterface

// File: rtl/l2_sqrt_stage_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered full flag.
//   clk, reset   clock and asynchronous active-low reset
//   push, din    write request and data; ignored when full unless popping
//   pop, dout    read request; dout shows the head entry (valid when !empty)
//   full         registered, count == DEPTH
//   empty        count == 0
//   count        current number of entries
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             wr_en_s;
    logic             rd_en_s;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign rd_en_s = pop && (count_q != {CNT_W{1'b0}});
    assign wr_en_s = push && ((count_q != CNT_W'(DEPTH)) || rd_en_s);

    // Occupancy next-state from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers, occupancy and the registered full flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            full_q   <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = (count_q == {CNT_W{1'b0}});
    assign count = count_q;

endmodule

// File: rtl/l2_sqrt_stage.sv
// -----------------------------------------------------------------------------
// l2_sqrt_stage
// Integer square root of the sum-of-squares stream: root = floor(sqrt(g)),
// rem = g - root*root, computed by a bit-serial restoring algorithm that
// retires one root bit per cycle. Samples are buffered in a small FIFO since
// the producer cannot be stalled; overflowed samples are counted in a sticky
// drop flag. The upstream overflow bit travels with each sample as a tag.
//   clk, reset   clock and asynchronous active-low reset
//   bus          l2_sqrt_stage_if.slave: sample in, result out, FIFO status
// Latency from the sampling edge to valid_out is OUT_W+1 edges when idle;
// a new result can be produced every OUT_W+2 cycles.
// -----------------------------------------------------------------------------
module l2_sqrt_stage
    import l2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    l2_sqrt_stage_if.slave  bus
);

    localparam int CNT_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int R_W    = OUT_W + 2;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    if ((IN_W % 2) != 0) begin : g_odd_in_w
        $error("l2_sqrt_stage: IN_W must be even");
    end

    fifo_entry_t       push_entry_s;
    fifo_entry_t       pop_entry_s;
    logic              pop_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [FCNT_W-1:0] fifo_count_s;

    sqrt_state_t       state_q, state_d;
    logic [IN_W-1:0]   a_q, a_d;
    logic [R_W-1:0]    r_q, r_d;
    logic [OUT_W-1:0]  q_q, q_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tag_q, tag_d;
    logic [OUT_W-1:0]  root_q, root_d;
    logic [OUT_W:0]    rem_q, rem_d;
    logic              ovf_out_q, ovf_out_d;
    logic              valid_q, valid_d;
    logic              drop_q, drop_d;

    logic [R_W-1:0]    r_shift_s;
    logic [R_W-1:0]    t_s;
    logic [R_W-1:0]    r_next_s;
    logic [OUT_W-1:0]  q_next_s;

    assign push_entry_s = {bus.ovf_in, bus.g_in};

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.valid_in),
        .pop   (pop_s),
        .din   (push_entry_s),
        .dout  (pop_entry_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // One restoring iteration: bring in the next radicand bit pair, trial-subtract 4q+1.
    // The remainder never exceeds 2q, so the dropped top bits of r_q<<2 are always zero.
    always_comb begin
        r_shift_s = (r_q << 2) | R_W'(a_q[IN_W-1 -: 2]);
        t_s       = {q_q, 2'b01};
        if (r_shift_s >= t_s) begin
            r_next_s = r_shift_s - t_s;
            q_next_s = (q_q << 1) | OUT_W'(1);
        end else begin
            r_next_s = r_shift_s;
            q_next_s = q_q << 1;
        end
    end

    // Control FSM, result capture and sticky drop detection.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        r_d       = r_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        tag_d     = tag_q;
        root_d    = root_q;
        rem_d     = rem_q;
        ovf_out_d = ovf_out_q;
        valid_d   = 1'b0;
        pop_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    a_d     = pop_entry_s.g;
                    tag_d   = pop_entry_s.ovf;
                    r_d     = {R_W{1'b0}};
                    q_d     = {OUT_W{1'b0}};
                    cnt_d   = CNT_W'(OUT_W - 1);
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                a_d = a_q << 2;
                r_d = r_next_s;
                q_d = q_next_s;
                // The result is registered on the last iteration so valid_out
                // is high exactly while the FSM sits in DONE.
                if (cnt_q == {CNT_W{1'b0}}) begin
                    root_d    = q_next_s;
                    rem_d     = r_next_s[OUT_W:0];
                    ovf_out_d = tag_q;
                    valid_d   = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = CALC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Same acceptance rule as the FIFO: a full FIFO still takes a sample
        // when the FSM pops in that cycle.
        drop_d = drop_q | (bus.valid_in & (fifo_count_s == FCNT_W'(FIFO_DEPTH)) & ~pop_s);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            a_q       <= {IN_W{1'b0}};
            r_q       <= {R_W{1'b0}};
            q_q       <= {OUT_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            tag_q     <= 1'b0;
            root_q    <= {OUT_W{1'b0}};
            rem_q     <= {(OUT_W+1){1'b0}};
            ovf_out_q <= 1'b0;
            valid_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            r_q       <= r_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
            root_q    <= root_d;
            rem_q     <= rem_d;
            ovf_out_q <= ovf_out_d;
            valid_q   <= valid_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.root      = root_q;
    assign bus.rem       = rem_q;
    assign bus.ovf_out   = ovf_out_q;
    assign bus.valid_out = valid_q;
    assign bus.fifo_full = fifo_full_s;
    assign bus.drop      = drop_q;

endmodule

// File: tb/tb_l2_sqrt_stage.sv
// -----------------------------------------------------------------------------
// tb_l2_sqrt_stage
// Directed bench for l2_sqrt_stage with hand-computed expectations.
// Each stimulus window drives a small per-edge table and records every
// valid_out pulse (edge index, root, rem, tag) plus fifo_full/drop history.
// -----------------------------------------------------------------------------
module tb_l2_sqrt_stage;
    import l2_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    l2_sqrt_stage_if bus ();

    l2_sqrt_stage #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run = 0;
    int fail_cnt  = 0;

    logic [IN_W-1:0]  sg        [64];
    logic             sv        [64];
    logic             so        [64];
    logic             full_hist [64];
    logic             drop_hist [64];
    int               p_idx  [$];
    logic [OUT_W-1:0] p_root [$];
    logic [OUT_W:0]   p_rem  [$];
    logic             p_ovf  [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 64; i++) begin
            sg[i]        = '0;
            sv[i]        = 1'b0;
            so[i]        = 1'b0;
            full_hist[i] = 1'b0;
            drop_hist[i] = 1'b0;
        end
        p_idx.delete();
        p_root.delete();
        p_rem.delete();
        p_ovf.delete();
    endtask

    // Called #1 after an edge; entry i is sampled by the i-th following edge.
    task automatic run_window(input int n);
        for (int i = 1; i <= n; i++) begin
            bus.valid_in = sv[i];
            bus.g_in     = sg[i];
            bus.ovf_in   = so[i];
            @(posedge clk);
            #1;
            full_hist[i] = bus.fifo_full;
            drop_hist[i] = bus.drop;
            if (bus.valid_out) begin
                p_idx.push_back(i);
                p_root.push_back(bus.root);
                p_rem.push_back(bus.rem);
                p_ovf.push_back(bus.ovf_out);
            end
        end
        bus.valid_in = 1'b0;
        bus.ovf_in   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int t2_g    [5] = '{0, 1, 15, 16, 1023};
    int t2_root [5] = '{0, 1, 3, 4, 31};
    int t2_rem  [5] = '{0, 0, 6, 0, 62};
    int bu_g    [6] = '{4, 9, 25, 36, 49, 64};
    int bu_root [5] = '{2, 3, 5, 6, 7};

    initial begin
        int total;
        int e;
        int nfull;

        bus.g_in     = '0;
        bus.valid_in = 1'b0;
        bus.ovf_in   = 1'b0;
        reset        = 1'b0;
        clear_stim();

        // Reset state
        #1;
        check_eq("rst_root",  bus.root,      32'd0);
        check_eq("rst_rem",   bus.rem,       32'd0);
        check_eq("rst_valid", bus.valid_out, 32'd0);
        check_eq("rst_ovf",   bus.ovf_out,   32'd0);
        check_eq("rst_full",  bus.fifo_full, 32'd0);
        check_eq("rst_drop",  bus.drop,      32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Singles: latency 6 edges after the sampling edge (index 7)
        for (int j = 0; j < 5; j++) begin
            clear_stim();
            sv[1] = 1'b1;
            sg[1] = IN_W'(t2_g[j]);
            run_window(10);
            check_eq("single_npulse", p_idx.size(), 32'd1);
            if (p_idx.size() == 1) begin
                check_eq("single_latency", p_idx[0],  32'd7);
                check_eq("single_root",    p_root[0], t2_root[j]);
                check_eq("single_rem",     p_rem[0],  t2_rem[j]);
            end
        end

        // Overflow tag propagation, back-to-back samples
        clear_stim();
        sv[1] = 1'b1; sg[1] = IN_W'(1023); so[1] = 1'b1;
        sv[2] = 1'b1; sg[2] = IN_W'(100);  so[2] = 1'b0;
        run_window(20);
        check_eq("ovf_npulse", p_idx.size(), 32'd2);
        if (p_idx.size() == 2) begin
            check_eq("ovf_idx0",  p_idx[0],  32'd7);
            check_eq("ovf_root0", p_root[0], 32'd31);
            check_eq("ovf_rem0",  p_rem[0],  32'd62);
            check_eq("ovf_tag0",  p_ovf[0],  32'd1);
            check_eq("ovf_idx1",  p_idx[1],  32'd14);
            check_eq("ovf_root1", p_root[1], 32'd10);
            check_eq("ovf_rem1",  p_rem[1],  32'd0);
            check_eq("ovf_tag1",  p_ovf[1],  32'd0);
        end

        // Burst of 6 into a 4-deep FIFO: 6th sample dropped
        clear_stim();
        for (int j = 0; j < 6; j++) begin
            sv[j+1] = 1'b1;
            sg[j+1] = IN_W'(bu_g[j]);
        end
        run_window(45);
        check_eq("burst_full_after4", full_hist[4], 32'd0);
        check_eq("burst_full_after5", full_hist[5], 32'd1);
        check_eq("burst_drop_after5", drop_hist[5], 32'd0);
        check_eq("burst_drop_after6", drop_hist[6], 32'd1);
        check_eq("burst_npulse", p_idx.size(), 32'd5);
        if (p_idx.size() == 5) begin
            for (int j = 0; j < 5; j++) begin
                check_eq("burst_idx",  p_idx[j],  7 + 7 * j);
                check_eq("burst_root", p_root[j], bu_root[j]);
                check_eq("burst_rem",  p_rem[j],  32'd0);
            end
        end
        check_eq("burst_drop_sticky", bus.drop, 32'd1);

        // valid_in low with toggling data: nothing moves
        clear_stim();
        for (int i = 1; i <= 50; i++) begin
            sg[i] = IN_W'($urandom);
        end
        run_window(50);
        nfull = 0;
        for (int i = 1; i <= 50; i++) begin
            if (full_hist[i]) nfull++;
        end
        check_eq("idle_npulse", p_idx.size(), 32'd0);
        check_eq("idle_full",   nfull,        32'd0);
        check_eq("idle_root",   bus.root,     32'd7);
        check_eq("idle_rem",    bus.rem,      32'd0);
        check_eq("idle_ovf",    bus.ovf_out,  32'd0);
        check_eq("idle_drop",   bus.drop,     32'd1);

        // Reset in the middle of a calculation
        clear_stim();
        sv[1] = 1'b1;
        sg[1] = IN_W'(1023);
        run_window(3);
        reset = 1'b0;
        #1;
        check_eq("midrst_root",  bus.root,      32'd0);
        check_eq("midrst_rem",   bus.rem,       32'd0);
        check_eq("midrst_valid", bus.valid_out, 32'd0);
        check_eq("midrst_ovf",   bus.ovf_out,   32'd0);
        check_eq("midrst_full",  bus.fifo_full, 32'd0);
        check_eq("midrst_drop",  bus.drop,      32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_stim();
        run_window(15);
        check_eq("midrst_no_pulse", p_idx.size(), 32'd0);
        check_eq("midrst_drop_after", bus.drop,   32'd0);

        // Exhaustive sweep against an independent integer square root
        total = 0;
        for (int g = 0; g < 1024; g++) begin
            clear_stim();
            sv[1] = 1'b1;
            sg[1] = IN_W'(g);
            run_window(8);
            total += p_idx.size();
            check_eq("sweep_one", p_idx.size(), 32'd1);
            if (p_idx.size() == 1) begin
                e = 0;
                while ((e + 1) * (e + 1) <= g) e++;
                check_eq("sweep_root", p_root[0], e);
                check_eq("sweep_rem",  p_rem[0],  g - e * e);
                check_eq("sweep_bound", (int'(p_rem[0]) <= 2 * int'(p_root[0])), 32'd1);
            end
        end
        check_eq("sweep_total", total, 32'd1024);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
